cmp_sar_search: RTL and testbench
=================================

// Module: cmp_sar_search
// PURPOSE
// Drives the A side of an external magnitude comparator (great/equal/less flags)
// and reads its flags back to recover the hidden value on the B side by
// successive approximation. It sits opposite our comparator blocks: the
// comparator turns two values into flags, and this block turns flags back
// into a value. Used for self-test and value discovery on comparator-based paths.
// PARAMETERS
// WIDTH    2  bit width of guess/result (>=1)
// CMP_LAT  0  idle cycles between driving a guess and sampling the flags (0..15)
// PORTS
// clk         in   1            rising-edge clock
// rst         in   1            synchronous, active-high reset
// start       in   1            begin search; sampled only in IDLE
// cmp_great   in   1            comparator flag: guess > target
// cmp_equal   in   1            comparator flag: guess == target
// cmp_less    in   1            comparator flag: guess < target
// guess       out  WIDTH        value presented to comparator A input
// busy        out  1            high while in PROBE/VERIFY
// done        out  1            one-cycle pulse when the search ends
// found       out  1            target matched; valid from done, held until next start
// err         out  1            flags not one-hot during a sample; held until next start
// result      out  WIDTH        recovered value; held until next start
// probes      out  $clog2(WIDTH+2)  number of comparator samples used
// BEHAVIOUR
// - Reset: state=IDLE; guess, result, probes = 0; busy, done, found, err = 0.
// - All outputs are registered. Flags are treated as combinational on guess.
// - States: IDLE, PROBE, VERIFY, DONE.
// - IDLE: start=1 -> PROBE with bit index i=WIDTH-1, acc=0, guess=1<<(WIDTH-1),
//   probes=0. found, err and result are cleared.
// - PROBE/VERIFY: hold guess for CMP_LAT cycles, then sample the flags on the next
//   cycle. A sample cycle increments probes.
// - PROBE sample:
//   - equal: result=guess, found=1 -> DONE (early exit).
//   - less: acc=guess (keep bit).
//   - great: acc unchanged (clear bit).
//   - if i>0: i--, guess=acc|(1<<i), stay in PROBE.
//   - if i==0: guess=acc -> VERIFY.
// - VERIFY sample:
//   - result=guess.
//   - equal: found=1; otherwise found=0 (faulty comparator).
//   - then -> DONE.
// - Invalid flags (zero or multiple asserted) at any sample: err=1, found=0,
//   result=guess -> DONE.
// - DONE: done=1 for exactly one cycle -> IDLE. guess keeps its last value.
// - start while busy or in DONE: ignored.
// - rst mid-search: next cycle is IDLE with reset values. No done pulse.
// - Max probes = WIDTH+1. Cycles from start to done = probes*(CMP_LAT+1)+1.
// - Flags are ignored outside sample cycles.
// TESTING (bench models an ideal comparator against target T, WIDTH=2, CMP_LAT=0 unless noted)
// T=2: start -> guess=10, equal -> done 2 cycles after start, result=2, found=1, probes=1
// T=3: guess 10 (less) then 11 (equal) -> result=3, found=1, probes=2
// T=0: guess 10 (great), 01 (great), VERIFY 00 (equal) -> result=0, found=1, probes=3
// Faults: flags=000 on first sample -> done, err=1, found=0, result=2;
//   comparator stuck at less -> VERIFY 11 fails, found=0
// CMP_LAT=3, T=1: each guess held 4 cycles; done 9 cycles after start, probes=2
// rst asserted in 2nd PROBE -> busy=0, guess=0 next cycle, no done;
//   start during busy ignored; exhaustive T=0..3 check

Source files
------------

// File: rtl/cmp_sar_search.sv
// Recovers the hidden B value of an external magnitude comparator by successive approximation on its A input.
// Latency: probes*(CMP_LAT+1)+1 cycles from the start cycle to the done pulse; at most WIDTH+1 probes.
// No backpressure: start is honoured only in IDLE, and the flags are sampled only on sample cycles.
module cmp_sar_search #(
  parameter int WIDTH   = 2,
  parameter int CMP_LAT = 0,
  localparam int PW     = $clog2(WIDTH + 2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             cmp_great,
  input  logic             cmp_equal,
  input  logic             cmp_less,
  output logic [WIDTH-1:0] guess,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic             err,
  output logic [WIDTH-1:0] result,
  output logic [PW-1:0]    probes
);

  localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_PROBE  = 2'd1,
    S_VERIFY = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] acc, acc_n;
  logic [3:0]       wait_cnt, wait_cnt_n;
  logic [WIDTH-1:0] guess_n, result_n;
  logic [PW-1:0]    probes_n;
  logic             busy_n, done_n, found_n, err_n;

  // Flags are trusted only when exactly one of them is asserted.
  logic [2:0]       flags;
  logic             flags_ok;
  logic [WIDTH-1:0] acc_keep;

  // Decode the comparator flags for the current guess.
  always_comb begin
    flags    = {cmp_great, cmp_equal, cmp_less};
    flags_ok = (flags == 3'b100) || (flags == 3'b010) || (flags == 3'b001);
    // A "less" answer means the target is above the guess, so the trial bit stays set.
    acc_keep = cmp_less ? guess : acc;
  end

  // Next-state and next-output logic; every register holds its value unless a branch changes it.
  always_comb begin
    state_n    = state;
    idx_n      = idx;
    acc_n      = acc;
    wait_cnt_n = wait_cnt;
    guess_n    = guess;
    result_n   = result;
    probes_n   = probes;
    busy_n     = busy;
    done_n     = 1'b0;
    found_n    = found;
    err_n      = err;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_n    = S_PROBE;
          idx_n      = IW'(WIDTH - 1);
          acc_n      = '0;
          wait_cnt_n = '0;
          guess_n    = WIDTH'(1) << (WIDTH - 1);
          probes_n   = '0;
          result_n   = '0;
          found_n    = 1'b0;
          err_n      = 1'b0;
          busy_n     = 1'b1;
        end
      end

      S_PROBE, S_VERIFY: begin
        if (wait_cnt != 4'(CMP_LAT)) begin
          // Give the comparator time to settle on the current guess.
          wait_cnt_n = wait_cnt + 4'd1;
        end else begin
          wait_cnt_n = '0;
          probes_n   = probes + PW'(1);
          if (!flags_ok) begin
            err_n    = 1'b1;
            found_n  = 1'b0;
            result_n = guess;
            state_n  = S_DONE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else if (state == S_VERIFY) begin
            // A final mismatch here points at a faulty comparator, not at the search.
            result_n = guess;
            found_n  = cmp_equal;
            state_n  = S_DONE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else if (cmp_equal) begin
            // Exact hit: stop early.
            result_n = guess;
            found_n  = 1'b1;
            state_n  = S_DONE;
            busy_n   = 1'b0;
            done_n   = 1'b1;
          end else if (idx != '0) begin
            acc_n   = acc_keep;
            idx_n   = idx - IW'(1);
            guess_n = acc_keep | (WIDTH'(1) << (idx - IW'(1)));
          end else begin
            // All bits decided; confirm the assembled value with one more sample.
            acc_n   = acc_keep;
            guess_n = acc_keep;
            state_n = S_VERIFY;
          end
        end
      end

      default: begin
        // S_DONE: the done pulse ends here, and guess keeps its last value.
        state_n = S_IDLE;
      end
    endcase
  end

  // Register the state and all outputs; reset returns to IDLE with cleared outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      idx      <= '0;
      acc      <= '0;
      wait_cnt <= '0;
      guess    <= '0;
      result   <= '0;
      probes   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      found    <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_n;
      idx      <= idx_n;
      acc      <= acc_n;
      wait_cnt <= wait_cnt_n;
      guess    <= guess_n;
      result   <= result_n;
      probes   <= probes_n;
      busy     <= busy_n;
      done     <= done_n;
      found    <= found_n;
      err      <= err_n;
    end
  end

endmodule

// File: tb/tb_cmp_sar_search.sv
// Directed bench for cmp_sar_search with an ideal or faulty comparator model.
// Two instances: CMP_LAT=0 for the main scenarios and CMP_LAT=3 for the latency case.
// Each scenario task drives stimulus and checks its own results inline.
module tb_cmp_sar_search;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance with CMP_LAT=0
  logic       start0 = 1'b0;
  logic       g0, e0, l0;
  logic [1:0] guess0, result0, probes0;
  logic       busy0, done0, found0, err0;
  logic [1:0] tgt0  = 2'd0;
  int         fault = 0;  // 0 ideal, 1 no flags, 2 stuck at less

  // Instance with CMP_LAT=3
  logic       start3 = 1'b0;
  logic       g3, e3, l3;
  logic [1:0] guess3, result3, probes3;
  logic       busy3, done3, found3, err3;
  logic [1:0] tgt3  = 2'd1;

  int n_checks = 0;
  int n_fail   = 0;

  logic [1:0] glog [16];
  int         glen;

  cmp_sar_search #(.WIDTH(2), .CMP_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0),
    .cmp_great(g0), .cmp_equal(e0), .cmp_less(l0),
    .guess(guess0), .busy(busy0), .done(done0), .found(found0), .err(err0),
    .result(result0), .probes(probes0)
  );

  cmp_sar_search #(.WIDTH(2), .CMP_LAT(3)) dut3 (
    .clk(clk), .rst(rst), .start(start3),
    .cmp_great(g3), .cmp_equal(e3), .cmp_less(l3),
    .guess(guess3), .busy(busy3), .done(done3), .found(found3), .err(err3),
    .result(result3), .probes(probes3)
  );

  // Comparator models: flags are combinational on guess
  always_comb begin
    case (fault)
      0:       {g0, e0, l0} = {guess0 > tgt0, guess0 == tgt0, guess0 < tgt0};
      1:       {g0, e0, l0} = 3'b000;
      default: {g0, e0, l0} = 3'b001;
    endcase
  end

  always_comb {g3, e3, l3} = {guess3 > tgt3, guess3 == tgt3, guess3 < tgt3};

  // Pulse start0 in an IDLE cycle, log guesses while busy, and count cycles up to done.
  task automatic run0(output int cyc, output bit tmo);
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc  = 1;
    glen = 0;
    tmo  = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy0 && glen < 16) begin
        glog[glen] = guess0;
        glen++;
      end
      if (done0) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (guess0 !== 2'd0 || result0 !== 2'd0 || probes0 !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_values: guess=%0d result=%0d probes=%0d, required 0 0 0",
               guess0, result0, probes0);
    end
    n_checks++;
    if ({busy0, done0, found0, err0} !== 4'b0000) begin
      n_fail++;
      $display("FAIL reset_flags: busy,done,found,err=%b, required 0000",
               {busy0, done0, found0, err0});
    end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_t2_early;
    int cyc; bit tmo;
    fault = 0; tgt0 = 2'd2;
    run0(cyc, tmo);
    n_checks++;
    if (tmo || cyc != 2) begin
      n_fail++;
      $display("FAIL t2_latency: cycles=%0d timeout=%0d, required 2", cyc, tmo);
    end
    n_checks++;
    if (result0 !== 2'd2 || found0 !== 1'b1 || probes0 !== 2'd1 || err0 !== 1'b0) begin
      n_fail++;
      $display("FAIL t2_outcome: result=%0d found=%b probes=%0d err=%b, required 2 1 1 0",
               result0, found0, probes0, err0);
    end
    n_checks++;
    if (glen != 1 || glog[0] !== 2'd2) begin
      n_fail++;
      $display("FAIL t2_guess: count=%0d first=%0d, required 1 guess of 2", glen, glog[0]);
    end
  endtask

  task automatic test_t3;
    int cyc; bit tmo;
    fault = 0; tgt0 = 2'd3;
    run0(cyc, tmo);
    n_checks++;
    if (tmo || glen != 2 || glog[0] !== 2'd2 || glog[1] !== 2'd3) begin
      n_fail++;
      $display("FAIL t3_guesses: count=%0d g0=%0d g1=%0d timeout=%0d, required 2,3",
               glen, glog[0], glog[1], tmo);
    end
    n_checks++;
    if (result0 !== 2'd3 || found0 !== 1'b1 || probes0 !== 2'd2 || cyc != 3) begin
      n_fail++;
      $display("FAIL t3_outcome: result=%0d found=%b probes=%0d cycles=%0d, required 3 1 2 3",
               result0, found0, probes0, cyc);
    end
    // Outcome stays put after done until the next start.
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_checks++;
    if (result0 !== 2'd3 || found0 !== 1'b1 || done0 !== 1'b0 || busy0 !== 1'b0) begin
      n_fail++;
      $display("FAIL t3_hold: result=%0d found=%b done=%b busy=%b, required 3 1 0 0",
               result0, found0, done0, busy0);
    end
  endtask

  task automatic test_t0_verify;
    int cyc; bit tmo;
    fault = 0; tgt0 = 2'd0;
    run0(cyc, tmo);
    n_checks++;
    if (tmo || glen != 3 || glog[0] !== 2'd2 || glog[1] !== 2'd1 || glog[2] !== 2'd0) begin
      n_fail++;
      $display("FAIL t0_guesses: count=%0d %0d,%0d,%0d timeout=%0d, required 2,1,0",
               glen, glog[0], glog[1], glog[2], tmo);
    end
    n_checks++;
    if (result0 !== 2'd0 || found0 !== 1'b1 || probes0 !== 2'd3 || cyc != 4) begin
      n_fail++;
      $display("FAIL t0_outcome: result=%0d found=%b probes=%0d cycles=%0d, required 0 1 3 4",
               result0, found0, probes0, cyc);
    end
  endtask

  task automatic test_no_flags;
    int cyc; bit tmo;
    fault = 1; tgt0 = 2'd1;
    run0(cyc, tmo);
    n_checks++;
    if (tmo || cyc != 2 || err0 !== 1'b1 || found0 !== 1'b0) begin
      n_fail++;
      $display("FAIL noflag_err: cycles=%0d err=%b found=%b timeout=%0d, required 2 1 0",
               cyc, err0, found0, tmo);
    end
    n_checks++;
    if (result0 !== 2'd2 || probes0 !== 2'd1) begin
      n_fail++;
      $display("FAIL noflag_result: result=%0d probes=%0d, required 2 1", result0, probes0);
    end
  endtask

  task automatic test_stuck_less;
    int cyc; bit tmo;
    fault = 2; tgt0 = 2'd1;
    run0(cyc, tmo);
    n_checks++;
    if (tmo || glen != 3 || glog[1] !== 2'd3 || glog[2] !== 2'd3) begin
      n_fail++;
      $display("FAIL stuck_guesses: count=%0d g1=%0d g2=%0d timeout=%0d, required 3,3",
               glen, glog[1], glog[2], tmo);
    end
    n_checks++;
    if (found0 !== 1'b0 || err0 !== 1'b0 || result0 !== 2'd3 || probes0 !== 2'd3) begin
      n_fail++;
      $display("FAIL stuck_outcome: found=%b err=%b result=%0d probes=%0d, required 0 0 3 3",
               found0, err0, result0, probes0);
    end
    fault = 0;
  endtask

  task automatic test_latency;
    int cyc; bit tmo;
    logic [1:0] lg [16];
    int n;
    tgt3 = 2'd1;
    @(posedge clk); #1;
    start3 = 1'b1;
    @(posedge clk); #1;
    start3 = 1'b0;
    cyc = 1; n = 0; tmo = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (busy3 && n < 16) begin
        lg[n] = guess3;
        n++;
      end
      if (done3) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (tmo || cyc != 9 || probes3 !== 2'd2 || result3 !== 2'd1 || found3 !== 1'b1) begin
      n_fail++;
      $display("FAIL lat3_outcome: cycles=%0d probes=%0d result=%0d found=%b timeout=%0d, required 9 2 1 1",
               cyc, probes3, result3, found3, tmo);
    end
    n_checks++;
    if (n != 8 || lg[0] !== 2'd2 || lg[3] !== 2'd2 || lg[4] !== 2'd1 || lg[7] !== 2'd1) begin
      n_fail++;
      $display("FAIL lat3_hold: busy cycles=%0d lg0=%0d lg3=%0d lg4=%0d lg7=%0d, required 8 cycles 2,2,1,1",
               n, lg[0], lg[3], lg[4], lg[7]);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    fault = 0; tgt0 = 2'd0;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    @(posedge clk); #1;
    n_checks++;
    if (guess0 !== 2'd1 || busy0 !== 1'b1) begin
      n_fail++;
      $display("FAIL rstmid_probe2: guess=%0d busy=%b, required 1 1", guess0, busy0);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    n_checks++;
    if (busy0 !== 1'b0 || guess0 !== 2'd0 || probes0 !== 2'd0) begin
      n_fail++;
      $display("FAIL rstmid_state: busy=%b guess=%0d probes=%0d, required 0 0 0",
               busy0, guess0, probes0);
    end
    seen = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (done0 || busy0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL rstmid_quiet: done or busy seen=%b after reset, required 0", seen);
    end
  endtask

  task automatic test_start_busy;
    int cyc; bit tmo, seen;
    fault = 0; tgt0 = 2'd0;
    @(posedge clk); #1;
    start0 = 1'b1;
    @(posedge clk); #1;  // search starts here
    start0 = 1'b0;
    @(posedge clk); #1;  // second probe, pulse start again
    start0 = 1'b1;
    @(posedge clk); #1;
    start0 = 1'b0;
    cyc = 3; tmo = 1'b1;
    repeat (100) begin
      @(negedge clk);
      if (done0) begin
        tmo = 1'b0;
        break;
      end
      @(posedge clk);
      cyc++;
    end
    n_checks++;
    if (tmo || cyc != 4 || probes0 !== 2'd3 || result0 !== 2'd0 || found0 !== 1'b1) begin
      n_fail++;
      $display("FAIL startbusy_outcome: cycles=%0d probes=%0d result=%0d found=%b timeout=%0d, required 4 3 0 1",
               cyc, probes0, result0, found0, tmo);
    end
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (busy0) seen = 1'b1;
    end
    n_checks++;
    if (seen) begin
      n_fail++;
      $display("FAIL startbusy_restart: busy after done=%b, required 0", seen);
    end
  endtask

  task automatic test_back_to_back;
    int cyc; bit tmo;
    int exp_p [4] = '{3, 2, 1, 2};
    fault = 0;
    for (int t = 0; t < 4; t++) begin
      tgt0 = 2'(t);
      run0(cyc, tmo);
      n_checks++;
      if (tmo || result0 !== 2'(t) || found0 !== 1'b1 || err0 !== 1'b0 ||
          probes0 !== 2'(exp_p[t]) || cyc != exp_p[t] + 1) begin
        n_fail++;
        $display("FAIL sweep_T%0d: result=%0d found=%b err=%b probes=%0d cycles=%0d timeout=%0d, required %0d 1 0 %0d %0d",
                 t, result0, found0, err0, probes0, cyc, tmo, t, exp_p[t], exp_p[t] + 1);
      end
    end
  endtask

  initial begin
    test_reset;
    test_t2_early;
    test_t3;
    test_t0_verify;
    test_no_flags;
    test_stuck_less;
    test_latency;
    test_reset_mid;
    test_start_busy;
    test_back_to_back;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
